card_mem_port_arbiter: RTL and testbench
========================================

// Module: card_mem_port_arbiter
// PURPOSE
//  Owns port B of the 16-entry x 6-bit card memory and shares it between three users:
//  the built-in board-clear sequencer, gameplay_sm writes, and cursor-card reads.
//  Adds a registered grant stage, read-latency tracking and a fairness cap on writes.
//  Sits between gameplay_sm / cursor logic and the dual-port card RAM; port A stays with VGA.
// PARAMETERS
//  AW          4         card address width (16 cards)
//  DW          6         card word: [5]=removed, [4]=face-down, [3:0]=value
//  RD_LAT      1         RAM read latency in clocks, address to mem_dout
//  WR_BURST    3         max consecutive write grants while a read is pending
//  CLR_WORD    6'b010000 word written by clear sweep (face-down, value 0)
// PORTS
//  Clk         in   1    system clock (DIV_CLK-derived clk)
//  Reset       in   1    synchronous, active-high
//  clr_start   in   1    1-cycle pulse: overwrite all 16 entries with CLR_WORD
//  clr_busy    out  1    high while sweep runs
//  clr_done    out  1    1-cycle pulse after last entry written
//  wr_req      in   1    gameplay_sm write request, held until wr_ack
//  wr_addr     in   AW   write address
//  wr_data     in   DW   write data
//  wr_ack      out  1    1-cycle pulse: write issued to RAM this cycle
//  rd_req      in   1    cursor read request, held until rd_ack
//  rd_addr     in   AW   read address (selectCard)
//  rd_ack      out  1    1-cycle pulse: rd_addr sampled and issued this cycle
//  rd_valid    out  1    1-cycle pulse RD_LAT cycles after rd_ack
//  rd_data     out  DW   card word; stable from rd_valid until next rd_valid
//  mem_we      out  1    RAM port-B write enable
//  mem_addr    out  AW   RAM port-B address
//  mem_din     out  DW   RAM port-B write data
//  mem_dout    in   DW   RAM port-B read data
// BEHAVIOUR
//  Reset: state=IDLE; all acks, clr_busy, clr_done, rd_valid, mem_we = 0; mem_addr=0,
//   mem_din=0, rd_data=0, write-burst counter=0, read pipeline flushed.
//  States: IDLE (serve wr/rd), CLEAR (sweep). IDLE->CLEAR on clr_start; CLEAR->IDLE
//   after addr 15 written, clr_done pulses in that transition cycle +1.
//  CLEAR: one write per clock, addr 0..15 in order (16 cycles); wr_ack/rd_ack held 0;
//   requests wait. clr_start during CLEAR ignored (no restart).
//  IDLE grant (one per cycle, registered outputs, issue in cycle after request seen):
//   wr_req && (!rd_req || burst<WR_BURST) -> write, burst++ if rd_req pending.
//   else rd_req -> read, burst=0. No requester: mem_we=0, burst=0.
//  Write grant: mem_we=1, mem_addr=wr_addr, mem_din=wr_data, wr_ack=1 same cycle.
//  Read grant: mem_we=0, mem_addr=rd_addr, rd_ack=1; shift token through RD_LAT-deep
//   pipeline; at exit rd_valid=1, rd_data<=mem_dout.
//  Requester must drop req the cycle after ack or it is re-granted (back-to-back allowed).
//  Same-address write then read: read issued later, returns new data (no bypass needed).
//  clr_start same cycle as wr_req/rd_req: clear wins; requests served after clr_done.
//  Reads in flight when clr_start arrives still complete with their rd_valid.
//  Reset mid-CLEAR: sweep aborted, no clr_done, RAM contents left partial.
//  Address counter AW bits; 15 is terminal, never wraps to 0 inside a sweep.
// STRUCTURE
//  card_pkg: DW, AW, bit indices REMOVED=5, FACEDOWN=4, CLR_WORD, NUM_CARDS=16.
//  Sub-module: rd_lat_pipe (RD_LAT-deep valid shift register); rest is one FSM + grant reg.
// TESTING
//  Reset, then clr_start -> clr_busy 16 cycles, mem_we addr 0..15 din 6'b010000, clr_done once.
//  wr_req addr 5 data 6'b000111 -> wr_ack 1 cycle, mem_we=1 addr 5; read addr 5 -> rd_data 6'b000111.
//  wr_req held 6 cycles + rd_req held -> 3 wr_acks, 1 rd_ack, then writes resume (WR_BURST=3).
//  clr_start with wr_req and rd_req asserted -> no acks for 16 cycles, write then read after.
//  rd_ack at cycle N -> rd_valid exactly at N+RD_LAT; rd_data held until next rd_valid.
//  Reset at sweep addr 7 -> next cycle mem_we=0, clr_busy=0, no clr_done, IDLE grants resume.

Source files
------------

// File: rtl/card_mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// card_mem_port_arbiter_pkg
// Shared definitions for the card memory port-B arbiter: card word geometry,
// field bit positions, the word written by the board-clear sweep, and the
// arbiter state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package card_mem_port_arbiter_pkg;

  localparam int CARD_AW   = 4;
  localparam int CARD_DW   = 6;
  localparam int NUM_CARDS = 16;

  // Card word layout: [5]=removed, [4]=face-down, [3:0]=value
  localparam int REMOVED  = 5;
  localparam int FACEDOWN = 4;

  // Cleared card: face-down, value 0, not removed
  localparam logic [CARD_DW-1:0] CARD_CLR_WORD = CARD_DW'(1) << FACEDOWN;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } arb_state_e;

  function automatic logic card_is_removed(input logic [CARD_DW-1:0] word);
    return word[REMOVED];
  endfunction

endpackage

// File: rtl/card_mem_port_arbiter_rd_lat_pipe.sv
// -----------------------------------------------------------------------------
// rd_lat_pipe
// Valid-token shift register matching the card RAM read latency. A token
// entering on tok_in (the cycle a read address is on the RAM bus) leaves on
// tok_out exactly DEPTH cycles later, when the RAM data is on mem_dout.
// Ports:
//   Clk      in   system clock
//   Reset    in   synchronous active-high, flushes all tokens
//   tok_in   in   read issued this cycle
//   tok_out  out  read data valid this cycle
// -----------------------------------------------------------------------------
module rd_lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic tok_in,
  output logic tok_out
);

  logic [DEPTH-1:0] vld_p;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= tok_in;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  assign tok_out = vld_p[DEPTH-1];

endmodule

// File: rtl/card_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// card_mem_port_arbiter
// Owns port B of the 16 x 6-bit card RAM and shares it between the built-in
// board-clear sweep, gameplay writes and cursor-card reads. All RAM-side
// outputs and acks are registered: a request seen at a clock edge is issued
// on the RAM bus (and acked) in the following cycle. Writes are capped at
// WR_BURST consecutive grants while a read is waiting.
// Ports:
//   Clk, Reset                  clock, synchronous active-high reset
//   clr_start / clr_busy / clr_done   board-clear control and status
//   wr_req, wr_addr, wr_data / wr_ack  write requester (req held until ack)
//   rd_req, rd_addr / rd_ack          read requester (req held until ack)
//   rd_valid, rd_data                 read return, RD_LAT cycles after rd_ack
//   mem_we, mem_addr, mem_din, mem_dout  RAM port B
// -----------------------------------------------------------------------------
module card_mem_port_arbiter
  import card_mem_port_arbiter_pkg::*;
#(
  parameter int              AW       = CARD_AW,
  parameter int              DW       = CARD_DW,
  parameter int              RD_LAT   = 1,
  parameter int              WR_BURST = 3,
  parameter logic [DW-1:0]   CLR_WORD = CARD_CLR_WORD
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int            BW        = $clog2(WR_BURST + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_CARDS - 1);

  arb_state_e    state, state_nx;
  logic [BW-1:0] burst, burst_nx;
  logic          we_nx;
  logic [AW-1:0] addr_nx;
  logic [DW-1:0] din_nx;
  logic          wr_ack_nx, rd_ack_nx, busy_nx, done_nx;
  logic [DW-1:0] rd_hold;

  // Next-state and next-output decode. The sweep reuses mem_addr as its
  // address counter; it stops at LAST_ADDR rather than wrapping.
  always_comb begin
    state_nx  = state;
    burst_nx  = burst;
    we_nx     = 1'b0;
    addr_nx   = mem_addr;
    din_nx    = mem_din;
    wr_ack_nx = 1'b0;
    rd_ack_nx = 1'b0;
    busy_nx   = 1'b0;
    done_nx   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (clr_start) begin
          // Clear outranks any pending request; requests keep waiting.
          state_nx = ST_CLEAR;
          we_nx    = 1'b1;
          addr_nx  = '0;
          din_nx   = CLR_WORD;
          busy_nx  = 1'b1;
        end else if (wr_req && (!rd_req || burst < BW'(WR_BURST))) begin
          we_nx     = 1'b1;
          addr_nx   = wr_addr;
          din_nx    = wr_data;
          wr_ack_nx = 1'b1;
          // Only writes that overtake a waiting read count toward the cap.
          if (rd_req) burst_nx = burst + 1'b1;
        end else if (rd_req) begin
          addr_nx   = rd_addr;
          rd_ack_nx = 1'b1;
          burst_nx  = '0;
        end else begin
          burst_nx = '0;
        end
      end

      ST_CLEAR: begin
        // clr_start is ignored here: a running sweep is never restarted.
        if (mem_addr == LAST_ADDR) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end else begin
          we_nx   = 1'b1;
          addr_nx = mem_addr + 1'b1;
          din_nx  = CLR_WORD;
          busy_nx = 1'b1;
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  // ---- grant stage: registered RAM bus and acks ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      burst    <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nx;
      burst    <= burst_nx;
      mem_we   <= we_nx;
      mem_addr <= addr_nx;
      mem_din  <= din_nx;
      wr_ack   <= wr_ack_nx;
      rd_ack   <= rd_ack_nx;
      clr_busy <= busy_nx;
      clr_done <= done_nx;
    end
  end

  // ---- read return: token follows the RAM latency ----
  rd_lat_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_lat_pipe (
    .Clk     (Clk),
    .Reset   (Reset),
    .tok_in  (rd_ack),
    .tok_out (rd_valid)
  );

  // mem_dout is only guaranteed during the rd_valid cycle, so it is passed
  // straight through then and captured for the hold period that follows.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_hold <= '0;
    end else if (rd_valid) begin
      rd_hold <= mem_dout;
    end
  end

  assign rd_data = rd_valid ? mem_dout : rd_hold;

endmodule

// File: tb/tb_card_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_card_mem_port_arbiter
// Directed bench for card_mem_port_arbiter with a 1-cycle-latency RAM model
// on port B. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_card_mem_port_arbiter;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       clr_start = 1'b0;
  logic       wr_req = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [5:0] wr_data = '0;
  logic       rd_req = 1'b0;
  logic [3:0] rd_addr = '0;
  logic       clr_busy, clr_done, wr_ack, rd_ack, rd_valid, mem_we;
  logic [5:0] rd_data, mem_din;
  logic [3:0] mem_addr;
  logic [5:0] mem_dout;
  logic [5:0] ram [16];

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] CLRW = 6'b010000;

  card_mem_port_arbiter dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  always #5 Clk = ~Clk;

  // Port-B RAM: synchronous write, registered read (1 cycle address->data)
  always @(posedge Clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [5:0] d);
    bit seen = 0;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wr_ack === 1'b1) begin seen = 1; break; end
    end
    wr_req = 1'b0;
    if (!seen) begin
      checks++; failures++;
      $display("FAIL wr_timeout addr=%0d no wr_ack within 40 cycles", a);
    end
    tick();
  endtask

  task automatic do_read(input logic [3:0] a, output logic [5:0] d);
    bit seen = 0;
    d = 'x;
    rd_req = 1'b1; rd_addr = a;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rd_ack === 1'b1) begin seen = 1; break; end
    end
    rd_req = 1'b0;
    if (seen) begin
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (rd_valid === 1'b1) begin seen = 1; d = rd_data; break; end
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL rd_timeout addr=%0d no rd_ack/rd_valid in time", a);
    end
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    checks++;
    if ({mem_we, wr_ack, rd_ack, rd_valid, clr_busy, clr_done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got we/wa/ra/rv/busy/done=%b required=000000",
               {mem_we, wr_ack, rd_ack, rd_valid, clr_busy, clr_done});
    end
    checks++;
    if (mem_addr !== 4'd0 || mem_din !== 6'd0 || rd_data !== 6'd0) begin
      failures++;
      $display("FAIL reset_data got addr=%0d din=%b rd_data=%b required 0/0/0",
               mem_addr, mem_din, rd_data);
    end
    Reset = 1'b0;
    tick();
    checks++;
    if (mem_we !== 1'b0 || clr_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got we=%b busy=%b required 0/0", mem_we, clr_busy);
    end
  endtask

  task automatic test_clear();
    int bad = 0;
    clr_start = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 4'(i) || mem_din !== CLRW ||
          clr_busy !== 1'b1 || clr_done !== 1'b0) begin
        failures++;
        $display("FAIL clr_step%0d got we=%b addr=%0d din=%b busy=%b done=%b required 1/%0d/%b/1/0",
                 i, mem_we, mem_addr, mem_din, clr_busy, clr_done, i, CLRW);
      end
      // a second clr_start mid-sweep must not restart it
      clr_start = (i == 5);
      tick();
    end
    clr_start = 1'b0;
    checks++;
    if (clr_done !== 1'b1 || clr_busy !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL clr_end got done=%b busy=%b we=%b required 1/0/0", clr_done, clr_busy, mem_we);
    end
    tick();
    checks++;
    if (clr_done !== 1'b0) begin
      failures++;
      $display("FAIL clr_done_pulse got done=%b required 0", clr_done);
    end
    for (int i = 0; i < 16; i++) if (ram[i] !== CLRW) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL clr_ram got %0d entries not cleared required 0", bad);
    end
  endtask

  task automatic test_write_read();
    wr_req = 1'b1; wr_addr = 4'd5; wr_data = 6'b000111;
    tick();
    checks++;
    if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'd5 || mem_din !== 6'b000111) begin
      failures++;
      $display("FAIL wr_issue got ack=%b we=%b addr=%0d din=%b required 1/1/5/000111",
               wr_ack, mem_we, mem_addr, mem_din);
    end
    wr_req = 1'b0;
    tick();
    checks++;
    if (wr_ack !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL wr_pulse got ack=%b we=%b required 0/0", wr_ack, mem_we);
    end
    rd_req = 1'b1; rd_addr = 4'd5;
    tick();
    checks++;
    if (rd_ack !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 4'd5 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_issue got ack=%b we=%b addr=%0d valid=%b required 1/0/5/0",
               rd_ack, mem_we, mem_addr, rd_valid);
    end
    rd_req = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 6'b000111 || rd_ack !== 1'b0) begin
      failures++;
      $display("FAIL rd_return got valid=%b data=%b ack=%b required 1/000111/0",
               rd_valid, rd_data, rd_ack);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 6'b000111) begin
      failures++;
      $display("FAIL rd_hold got valid=%b data=%b required 0/000111", rd_valid, rd_data);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_w = 8'b0011_0111;  // bit i = wr_ack in cycle i
    logic [7:0] exp_r = 8'b0000_1000;
    logic [7:0] exp_v = 8'b0001_0000;
    int nw = 0;
    wr_req = 1'b1; wr_addr = 4'd9; wr_data = 6'b100001;
    rd_req = 1'b1; rd_addr = 4'd3;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (wr_ack !== exp_w[i] || rd_ack !== exp_r[i] || rd_valid !== exp_v[i] ||
          (exp_v[i] && rd_data !== CLRW)) begin
        failures++;
        $display("FAIL burst_cyc%0d got wa=%b ra=%b rv=%b data=%b required %b/%b/%b data=%b",
                 i, wr_ack, rd_ack, rd_valid, rd_data, exp_w[i], exp_r[i], exp_v[i], CLRW);
      end
      if (rd_ack === 1'b1) rd_req = 1'b0;
      if (wr_ack === 1'b1) begin
        nw++;
        if (nw == 5) wr_req = 1'b0;
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    tick();
  endtask

  task automatic test_read_across_clear();
    rd_req = 1'b1; rd_addr = 4'd5;
    tick();
    checks++;
    if (rd_ack !== 1'b1 || mem_addr !== 4'd5) begin
      failures++;
      $display("FAIL rdclr_issue got ack=%b addr=%0d required 1/5", rd_ack, mem_addr);
    end
    rd_req = 1'b0; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 6'b000111 || clr_busy !== 1'b1 ||
        mem_we !== 1'b1 || mem_addr !== 4'd0) begin
      failures++;
      $display("FAIL rdclr_inflight got rv=%b data=%b busy=%b we=%b addr=%0d required 1/000111/1/1/0",
               rd_valid, rd_data, clr_busy, mem_we, mem_addr);
    end
    for (int i = 1; i < 16; i++) tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 6'b000111 || mem_addr !== 4'd15) begin
      failures++;
      $display("FAIL rdclr_hold got rv=%b data=%b addr=%0d required 0/000111/15",
               rd_valid, rd_data, mem_addr);
    end
    tick();
    checks++;
    if (clr_done !== 1'b1) begin
      failures++;
      $display("FAIL rdclr_done got done=%b required 1", clr_done);
    end
    tick();
  endtask

  task automatic test_clear_priority();
    int acks = 0;
    clr_start = 1'b1;
    wr_req = 1'b1; wr_addr = 4'd2; wr_data = 6'b000101;
    rd_req = 1'b1; rd_addr = 4'd2;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (wr_ack !== 1'b0 || rd_ack !== 1'b0) acks++;
      tick();
    end
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL prio_no_ack got %0d ack cycles during sweep required 0", acks);
    end
    checks++;
    if (clr_done !== 1'b1 || wr_ack !== 1'b0 || rd_ack !== 1'b0) begin
      failures++;
      $display("FAIL prio_done got done=%b wa=%b ra=%b required 1/0/0", clr_done, wr_ack, rd_ack);
    end
    tick();
    checks++;
    if (wr_ack !== 1'b1 || rd_ack !== 1'b0 || mem_addr !== 4'd2 || mem_din !== 6'b000101) begin
      failures++;
      $display("FAIL prio_write got wa=%b ra=%b addr=%0d din=%b required 1/0/2/000101",
               wr_ack, rd_ack, mem_addr, mem_din);
    end
    wr_req = 1'b0;
    tick();
    checks++;
    if (rd_ack !== 1'b1 || wr_ack !== 1'b0 || mem_addr !== 4'd2) begin
      failures++;
      $display("FAIL prio_read got ra=%b wa=%b addr=%0d required 1/0/2", rd_ack, wr_ack, mem_addr);
    end
    rd_req = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 6'b000101) begin
      failures++;
      $display("FAIL prio_data got rv=%b data=%b required 1/000101", rd_valid, rd_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    logic [5:0] d;
    do_write(4'd12, 6'b101010);
    do_write(4'd3,  6'b010101);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (mem_addr !== 4'd7 || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL mid_addr got addr=%0d we=%b required 7/1", mem_addr, mem_we);
    end
    Reset = 1'b1;
    tick();
    checks++;
    if (mem_we !== 1'b0 || clr_busy !== 1'b0 || clr_done !== 1'b0 || mem_addr !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset got we=%b busy=%b done=%b addr=%0d required 0/0/0/0",
               mem_we, clr_busy, clr_done, mem_addr);
    end
    Reset = 1'b0;
    tick();
    checks++;
    if (clr_done !== 1'b0 || clr_busy !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL mid_no_done got done=%b busy=%b we=%b required 0/0/0", clr_done, clr_busy, mem_we);
    end
    do_read(4'd12, d);
    checks++;
    if (d !== 6'b101010) begin
      failures++;
      $display("FAIL mid_untouched got %b required 101010", d);
    end
    do_read(4'd3, d);
    checks++;
    if (d !== CLRW) begin
      failures++;
      $display("FAIL mid_cleared got %b required %b", d, CLRW);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write_read();
    test_fairness();
    test_read_across_clear();
    test_clear_priority();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
